vector_lsu: RTL and testbench
=============================

// Module: vector_lsu
// PURPOSE
//  Vector load/store unit: the initiator that drives the 64-bit vector data cache port.
//  - Accepts one strided multi-beat request from the vector pipeline.
//  - Issues one cache access per beat, and streams load data back or takes store data in.
//  - Sits between vector execute stage and dcache_vector-style responder (address/read/write/data/valid).
// PARAMETERS
//  WIDTH      32  address width
//  VEC_WIDTH  64  vector word width (cache line word)
//  CNT_W      3   width of beat count; max request = 2**CNT_W-1 beats
// PORTS
//  CLK           in   1          clock; all logic on posedge
//  RST           in   1          synchronous, active-high reset
//  req_valid     in   1          pipeline request strobe
//  req_ready     out  1          unit idle, can accept request
//  req_write     in   1          1=store, 0=load
//  req_addr      in   WIDTH      base byte address
//  req_stride    in   WIDTH      byte stride between beats
//  req_count     in   CNT_W      number of beats (0 legal, see below)
//  wdata         in   VEC_WIDTH  store data beat
//  wdata_valid   in   1          store data available
//  wdata_ready   out  1          store beat consumed this cycle
//  rdata         out  VEC_WIDTH  load data beat (registered)
//  rdata_valid   out  1          rdata valid, single-cycle per beat
//  rdata_last    out  1          marks final load beat
//  done          out  1          one-cycle pulse, request complete
//  mem_address   out  WIDTH      cache address
//  mem_data_in   out  VEC_WIDTH  cache write data
//  mem_read      out  1          cache read strobe
//  mem_write     out  1          cache write strobe (cache writes on the posedge where it is high)
//  mem_data_out  in   VEC_WIDTH  cache read data (combinational from cache)
//  mem_valid     in   1          cache response/acceptance valid
// BEHAVIOUR
//  States: IDLE, LOAD, STORE, DONE.
//  Reset: state=IDLE; rdata=0, rdata_valid=0, rdata_last=0, done=0, mem_read=0, mem_write=0.
//    mem_address=0, mem_data_in=0. req_ready=1 the first cycle after RST deasserts; forced 0 while RST high.
//  IDLE: req_ready=1. Accept on req_valid&req_ready: latch addr/stride/count/write.
//    count==0 -> DONE; else write? STORE : LOAD.
//  LOAD: mem_read=1, mem_address=cur_addr.
//    Beat completes on a cycle with mem_valid=1: capture mem_data_out into rdata.
//    rdata_valid=1 the following cycle (1-cycle latency per beat).
//    Then cur_addr+=stride, beats_left-=1. Final beat -> DONE.
//  STORE: mem_data_in=wdata, mem_address=cur_addr, mem_write=wdata_valid.
//    wdata_ready=wdata_valid&mem_valid. Beat completes when both are high; then advance as LOAD.
//    Gaps in wdata_valid stall with mem_write=0.
//  Stall: mem_valid=0 holds mem_address and strobes unchanged; no beat advances.
//  DONE: exactly one cycle. done=1, req_ready=0; then -> IDLE.
//    For loads, rdata_valid=rdata_last=1 in the same cycle as done.
//    A req_valid during DONE is not accepted.
//  Address arithmetic: WIDTH-bit add, wraps mod 2**WIDTH. Low 3 bits passed unchanged.
//    Cache ignores bits [2:0]; stride 8 = consecutive words.
//  mem_read and mem_write are never high together. Both are 0 in IDLE/DONE.
//  RST mid-operation: abandon request at the next edge. No done pulse, no further strobes.
//    Partial store beats already written stay written.
// STRUCTURE
//  vec_mem_defs.vh: state encodings (IDLE/LOAD/STORE/DONE), VEC_WIDTH, word-byte shift (3).
//  Sub-module vector_addr_gen: holds cur_addr and beats_left.
//    Inputs: load, base/stride/count, step. Outputs: addr, last.
//    FSM, data register and strobes stay in vector_lsu.
// TESTING (bench with dcache_vector after reset, plus a stub cache with controllable mem_valid)
//  1 load base 0x20 stride 0x10 count 2
//    -> rdata 0x0004000400040004, then 0x0006000600060006; last+done on 2nd beat.
//  2 store base 0x80 stride 8 count 3, data A/B/C with wdata_valid gapped
//    -> 3 mem_write pulses only; reload of 0x80 count 3 returns A,B,C.
//  3 stub holds mem_valid=0 for 3 cycles during load beat 1
//    -> mem_read and mem_address stable; no rdata_valid until release.
//  4 req_count=0 -> done the cycle after accept; mem_read/mem_write never asserted.
//  5 RST high during load beat 2 of 4
//    -> next cycle mem_read=0, rdata_valid=0, no done; new load after release is correct.
//  6 base 0xFFFFFFF8 stride 8 count 2 -> mem_address 0xFFFFFFF8, then 0x00000000.

Source files
------------

// File: rtl/vector_lsu_pkg.sv
// Shared definitions for the vector load/store unit: FSM state encoding and default widths.
package vector_lsu_pkg;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_VEC_WIDTH = 64;
    localparam int unsigned DEF_CNT_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/vector_lsu_addr_gen.sv
// Strided address generator: holds the current beat address and the number of beats left.
module vector_lsu_addr_gen
    import vector_lsu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_base,
    input  logic [WIDTH-1:0] i_stride,
    input  logic [CNT_W-1:0] i_count,
    output logic [WIDTH-1:0] o_addr,
    output logic             o_last
);

    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_stride;
    logic [CNT_W-1:0] r_left;

    // Plain modular add: the low word-offset bits ride along untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_stride <= '0;
            r_left   <= '0;
        end else if (i_load) begin
            r_addr   <= i_base;
            r_stride <= i_stride;
            r_left   <= i_count;
        end else if (i_step) begin
            r_addr   <= r_addr + r_stride;
            r_left   <= r_left - CNT_W'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_left == CNT_W'(1));

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: turns one strided multi-beat request into per-beat cache accesses.
module vector_lsu
    import vector_lsu_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned VEC_WIDTH = DEF_VEC_WIDTH,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [WIDTH-1:0]     req_addr,
    input  logic [WIDTH-1:0]     req_stride,
    input  logic [CNT_W-1:0]     req_count,
    input  logic [VEC_WIDTH-1:0] wdata,
    input  logic                 wdata_valid,
    output logic                 wdata_ready,
    output logic [VEC_WIDTH-1:0] rdata,
    output logic                 rdata_valid,
    output logic                 rdata_last,
    output logic                 done,
    output logic [WIDTH-1:0]     mem_address,
    output logic [VEC_WIDTH-1:0] mem_data_in,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic [VEC_WIDTH-1:0] mem_data_out,
    input  logic                 mem_valid
);

    lsu_state_e r_state;
    lsu_state_e w_state_next;

    logic [VEC_WIDTH-1:0] r_rdata;
    logic                 r_rdata_valid;
    logic                 r_rdata_last;

    logic                 w_accept;
    logic                 w_step;
    logic                 w_load_beat;
    logic                 w_last;
    logic [WIDTH-1:0]     w_cur_addr;

    vector_lsu_addr_gen #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_addr_gen (
        .clk      (CLK),
        .rst      (RST),
        .i_load   (w_accept),
        .i_step   (w_step),
        .i_base   (req_addr),
        .i_stride (req_stride),
        .i_count  (req_count),
        .o_addr   (w_cur_addr),
        .o_last   (w_last)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_load_beat  = 1'b0;
        req_ready    = 1'b0;
        wdata_ready  = 1'b0;
        done         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = '0;
        mem_data_in  = '0;
        unique case (r_state)
            ST_IDLE: begin
                req_ready = !RST;
                if (req_valid && !RST) begin
                    w_accept = 1'b1;
                    if (req_count == '0)  w_state_next = ST_DONE;
                    else if (req_write)   w_state_next = ST_STORE;
                    else                  w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mem_read    = 1'b1;
                mem_address = w_cur_addr;
                if (mem_valid) begin
                    w_step      = 1'b1;
                    w_load_beat = 1'b1;
                    if (w_last) w_state_next = ST_DONE;
                end
            end
            ST_STORE: begin
                mem_write   = wdata_valid;
                mem_address = w_cur_addr;
                mem_data_in = wdata;
                if (wdata_valid && mem_valid) begin
                    wdata_ready = 1'b1;
                    w_step      = 1'b1;
                    if (w_last) w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Load data lands one cycle after its beat; the final beat coincides with done.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_rdata_last  <= 1'b0;
        end else begin
            r_rdata_valid <= w_load_beat;
            r_rdata_last  <= w_load_beat && w_last;
            if (w_load_beat) r_rdata <= mem_data_out;
        end
    end

    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign rdata_last  = r_rdata_last;

endmodule

// File: tb/tb_vector_lsu.sv
// Directed bench for vector_lsu against a small word-addressed cache model with gateable mem_valid.
module tb_vector_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_stride;
    logic [2:0]  req_count;
    logic [63:0] wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [63:0] rdata;
    logic        rdata_valid;
    logic        rdata_last;
    logic        done;
    logic [31:0] mem_address;
    logic [63:0] mem_data_in;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_data_out;
    logic        mem_valid;

    int total = 0;
    int bad   = 0;
    int wr_pulses = 0;
    int wr_base;

    logic [63:0] mem [0:255];
    logic [63:0] got [0:7];
    int          got_n;

    localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
    localparam logic [63:0] DB = 64'h5555_6666_7777_8888;
    localparam logic [63:0] DC = 64'h9999_AAAA_BBBB_CCCC;

    always #5 clk = ~clk;

    vector_lsu #(
        .WIDTH     (32),
        .VEC_WIDTH (64),
        .CNT_W     (3)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_stride   (req_stride),
        .req_count    (req_count),
        .wdata        (wdata),
        .wdata_valid  (wdata_valid),
        .wdata_ready  (wdata_ready),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .rdata_last   (rdata_last),
        .done         (done),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out),
        .mem_valid    (mem_valid)
    );

    // Word k initially holds {4{k[15:0]}}; index by address bits [10:3].
    initial begin
        for (int k = 0; k < 256; k++) mem[k] = {4{16'(k)}};
    end
    assign mem_data_out = mem[mem_address[10:3]];
    always @(posedge clk) begin
        if (mem_write && mem_valid) mem[mem_address[10:3]] <= mem_data_in;
        if (mem_write) wr_pulses <= wr_pulses + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input logic [31:0] a, input logic [31:0] s, input logic [2:0] c);
        logic seen_done;
        seen_done = 1'b0;
        got_n = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_stride = s; req_count = c;
        step();
        req_valid = 1'b0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (rdata_valid && got_n < 8) begin
                got[got_n] = rdata;
                got_n++;
            end
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            step();
        end
        chk("load_done_seen", seen_done, 1'b1);
        chk("load_beats", got_n, c);
        step();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_stride = '0;
        req_count = '0; wdata = '0; wdata_valid = 1'b0; mem_valid = 1'b1;

        // reset
        step(); step();
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rdata", rdata, 64'h0);
        chk("rst_rdata_valid", rdata_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_address", mem_address, 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", req_ready, 1'b1);

        // 1: load 0x20 stride 0x10 count 2
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_stride = 32'h10; req_count = 3'd2;
        step();
        req_valid = 1'b0;
        #1;
        chk("t1_read0", mem_read, 1'b1);
        chk("t1_addr0", mem_address, 32'h20);
        chk("t1_nowrite", mem_write, 1'b0);
        step();
        chk("t1_rv0", rdata_valid, 1'b1);
        chk("t1_rd0", rdata, 64'h0004000400040004);
        chk("t1_last0", rdata_last, 1'b0);
        chk("t1_done0", done, 1'b0);
        chk("t1_addr1", mem_address, 32'h30);
        step();
        chk("t1_rd1", rdata, 64'h0006000600060006);
        chk("t1_rv1", rdata_valid, 1'b1);
        chk("t1_last1", rdata_last, 1'b1);
        chk("t1_done1", done, 1'b1);
        chk("t1_ready_done", req_ready, 1'b0);
        chk("t1_read_done", mem_read, 1'b0);
        step();
        chk("t1_idle_ready", req_ready, 1'b1);
        chk("t1_idle_rv", rdata_valid, 1'b0);
        chk("t1_idle_done", done, 1'b0);

        // 2: store 0x80 stride 8 count 3 with gaps in wdata_valid
        wr_base = wr_pulses;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h80; req_stride = 32'h8; req_count = 3'd3;
        step();
        req_valid = 1'b0; wdata_valid = 1'b0;
        #1;
        chk("t2_gap0_write", mem_write, 1'b0);
        chk("t2_gap0_ready", wdata_ready, 1'b0);
        chk("t2_addr0", mem_address, 32'h80);
        step();
        wdata = DA; wdata_valid = 1'b1;
        #1;
        chk("t2_wA", mem_write, 1'b1);
        chk("t2_wA_ready", wdata_ready, 1'b1);
        chk("t2_wA_data", mem_data_in, DA);
        step();
        wdata_valid = 1'b0;
        #1;
        chk("t2_gap1_write", mem_write, 1'b0);
        chk("t2_addr1", mem_address, 32'h88);
        step();
        wdata = DB; wdata_valid = 1'b1;
        #1;
        chk("t2_wB", mem_write, 1'b1);
        chk("t2_addr1b", mem_address, 32'h88);
        step();
        wdata = DC;
        #1;
        chk("t2_addr2", mem_address, 32'h90);
        chk("t2_wC_data", mem_data_in, DC);
        step();
        wdata_valid = 1'b0;
        #1;
        chk("t2_done", done, 1'b1);
        chk("t2_done_write", mem_write, 1'b0);
        chk("t2_done_rv", rdata_valid, 1'b0);
        chk("t2_pulses", wr_pulses - wr_base, 3);
        step();
        run_load(32'h80, 32'h8, 3'd3);
        chk("t2_reload0", got[0], DA);
        chk("t2_reload1", got[1], DB);
        chk("t2_reload2", got[2], DC);

        // 3: mem_valid held low for 3 cycles during load beat 1
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_stride = 32'h10; req_count = 3'd2;
        step();
        req_valid = 1'b0; mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_stall_read", mem_read, 1'b1);
            chk("t3_stall_addr", mem_address, 32'h40);
            chk("t3_stall_rv", rdata_valid, 1'b0);
            step();
        end
        mem_valid = 1'b1;
        step();
        chk("t3_rv0", rdata_valid, 1'b1);
        chk("t3_rd0", rdata, 64'h0008000800080008);
        chk("t3_addr1", mem_address, 32'h50);
        step();
        chk("t3_done", done, 1'b1);
        chk("t3_rd1", rdata, 64'h000A000A000A000A);
        step();

        // 4: zero-count request, and a req_valid during DONE is ignored
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100; req_stride = 32'h8; req_count = 3'd0;
        #1;
        chk("t4_accept_read", mem_read, 1'b0);
        step();
        req_count = 3'd2;
        #1;
        chk("t4_done", done, 1'b1);
        chk("t4_read", mem_read, 1'b0);
        chk("t4_write", mem_write, 1'b0);
        chk("t4_rv", rdata_valid, 1'b0);
        chk("t4_ready_done", req_ready, 1'b0);
        step();
        chk("t4_not_accepted", mem_read, 1'b0);
        chk("t4_idle_ready", req_ready, 1'b1);
        req_valid = 1'b0;
        step();

        // 5: reset during beat 2 of 4, then a fresh load
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0; req_stride = 32'h8; req_count = 3'd4;
        step();
        req_valid = 1'b0;
        #1;
        chk("t5_addr0", mem_address, 32'h0);
        step();
        chk("t5_addr1", mem_address, 32'h8);
        chk("t5_rv0", rdata_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("t5_rst_ready", req_ready, 1'b0);
        step();
        chk("t5_read", mem_read, 1'b0);
        chk("t5_rv", rdata_valid, 1'b0);
        chk("t5_done", done, 1'b0);
        rst = 1'b0;
        #1;
        chk("t5_ready", req_ready, 1'b1);
        chk("t5_done2", done, 1'b0);
        run_load(32'h18, 32'h8, 3'd2);
        chk("t5_ld0", got[0], 64'h0003000300030003);
        chk("t5_ld1", got[1], 64'h0004000400040004);

        // 6: address wrap
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hFFFF_FFF8; req_stride = 32'h8; req_count = 3'd2;
        step();
        req_valid = 1'b0;
        #1;
        chk("t6_addr0", mem_address, 32'hFFFF_FFF8);
        step();
        chk("t6_addr1", mem_address, 32'h0);
        chk("t6_rd0", rdata, 64'h00FF00FF00FF00FF);
        step();
        chk("t6_done", done, 1'b1);
        chk("t6_rd1", rdata, 64'h0);
        chk("t6_last", rdata_last, 1'b1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
